// File: rtl/loom_arith_pkg.sv
// rtl/loom_arith_pkg.sv - shared arithmetic types and helpers for the divider slice
`ifndef LOOM_ABS_U
// Unsigned magnitude of a two's-complement value of width w; INT_MIN maps to 2^(w-1).
`define LOOM_ABS_U(x, w) (x[(w)-1] ? ((~x) + w'(1)) : x)
`endif

package loom_arith_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_t;

  localparam int DIV_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/arith_div_core.sv
// rtl/arith_div_core.sv - unsigned restoring divider, one quotient bit per cycle
module arith_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] quot_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // One extra bit on the trial remainder so the shift never loses the top bit.
  always_comb begin
    trial  = {rem_q, dvd_q[cnt_q]};
    diff   = trial - {1'b0, dvs_q};
    rem_d  = trial[WIDTH-1:0];
    quot_d = quot_q;
    if (trial >= {1'b0, dvs_q}) begin
      rem_d         = diff[WIDTH-1:0];
      quot_d[cnt_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        dvd_q  <= dividend_i;
        dvs_q  <= divisor_i;
        rem_q  <= '0;
        quot_q <= '0;
        cnt_q  <= CW'(WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/arith_divsi.sv
// rtl/arith_divsi.sv - signed divider: join handshake, sign fix-up, result hold
module arith_divsi
  import loom_arith_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data
);

  div_state_t       state_q;
  div_state_t       state_d;
  logic             neg_q;
  logic             dz_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             accept;
  logic             core_done;
  logic [WIDTH-1:0] core_quot;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign abs_a = `LOOM_ABS_U(a_data, WIDTH);
  assign abs_b = `LOOM_ABS_U(b_data, WIDTH);

  arith_div_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (accept),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .done_o     (core_done),
    .quot_o     (core_quot)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    accept  = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        accept = rst_n & a_valid & b_valid;
        if (accept) state_d = DIV_CALC;
      end
      DIV_CALC: begin
        // A zero divisor bypasses the core result; the core run is simply ignored.
        if (dz_q) begin
          state_d = DIV_DONE;
          res_d   = '1;
        end else if (core_done) begin
          state_d = DIV_DONE;
          res_d   = neg_q ? ((~core_quot) + WIDTH'(1)) : core_quot;
        end
      end
      DIV_DONE: begin
        if (result_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (accept) begin
        neg_q <= a_data[WIDTH-1] ^ b_data[WIDTH-1];
        dz_q  <= (b_data == '0);
      end
    end
  end

  assign a_ready      = accept;
  assign b_ready      = accept;
  assign result_valid = (state_q == DIV_DONE);
  assign result_data  = res_q;

endmodule

// File: tb/tb_arith_divsi.sv
// tb/tb_arith_divsi.sv - directed vector bench for arith_divsi at WIDTH=32
module tb_arith_divsi;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    int           lat;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] result_data;

  int total;
  int bad;
  int hs_cnt;

  arith_divsi #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_data       (b_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && result_valid && result_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!result_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input int lat_exp);
    int lat;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = a;
    b_data = b;
    result_ready = 1'b1;
    @(negedge clk);
    check({name, " accept"}, {30'd0, a_ready, b_ready}, 32'd3);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    wait_result(lat);
    check({name, " latency"}, lat, lat_exp);
    check({name, " quotient"}, result_data, q);
    @(posedge clk);
    #1;
    check({name, " valid clears"}, {31'd0, result_valid}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    int hs0;
    int seen;
    total = 0;
    bad = 0;
    hs_cnt = 0;
    vecs = '{
      '{32'd7,          32'd2,          32'd3,          33},
      '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33},
      '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33},
      '{32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          33},
      '{32'd5,          32'd0,          32'hFFFFFFFF,   1},
      '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33},
      '{32'h80000000,   32'd2,          32'hC0000000,   33},
      '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   33},
      '{32'd0,          32'd5,          32'd0,          33},
      '{32'hFFFFFFFF,   32'd2,          32'd0,          33},
      '{32'd1000,       32'hFFFFFFFD,   32'hFFFFFEB3,   33},
      '{32'd3,          32'd7,          32'd0,          33},
      '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          33},
      '{32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   1}
    };

    rst_n = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 32'd7;
    b_data = 32'd2;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result_valid", {31'd0, result_valid}, 32'd0);
    check("reset result_data", result_data, 32'd0);
    check("reset ready", {30'd0, a_ready, b_ready}, 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lat);

    // Back-pressure: result held, while a second operand pair waits at the inputs.
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 32'd9;
    b_data = 32'd3;
    result_ready = 1'b0;
    @(posedge clk);
    #1;
    a_data = 32'd20;
    b_data = 32'd4;
    wait_result(lat);
    check("hold latency", lat, 33);
    hs0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold valid", {31'd0, result_valid}, 32'd1);
      check("hold data", result_data, 32'd3);
      check("hold ready", {30'd0, a_ready, b_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("release valid clears", {31'd0, result_valid}, 32'd0);
    check("release one handshake", hs_cnt - hs0, 32'd1);
    @(negedge clk);
    check("held pair accepted", {30'd0, a_ready, b_ready}, 32'd3);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    wait_result(lat);
    check("held pair latency", lat, 33);
    check("held pair quotient", result_data, 32'd5);
    result_ready = 1'b1;
    @(posedge clk);
    #1;

    // Join: dividend alone must not be accepted.
    a_valid = 1'b1;
    b_valid = 1'b0;
    a_data = 32'd50;
    b_data = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("join a only", {30'd0, a_ready, b_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    run_op("join", 32'd50, 32'd5, 32'd10, 33);

    // Reset in the middle of CALC abandons the operation.
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 32'd1000;
    b_data = 32'd3;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset valid", {31'd0, result_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) seen++;
    end
    check("midreset no output", seen, 32'd0);
    run_op("after reset", 32'd100, 32'd7, 32'd14, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
